// File: rtl/muldiv_hilo_unit.sv
// Iterative radix-2 multiply/divide unit holding the architectural HI/LO registers.
// A start takes W CALC cycles plus one FIX cycle, where HI/LO are written.
module muldiv_hilo_unit #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   con,
    input  logic         hiloW,
    input  logic         hiloR,
    input  logic         hiloS,
    input  logic         abort,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] hiloOut,
    output logic         busy,
    output logic         stall,
    output logic         done,
    output logic         divz
);

    localparam int unsigned CW = $clog2(W);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [W-1:0]   opb_q, opb_d, a_raw_q, a_raw_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           div_q, div_d, sgn_q, sgn_d, sa_q, sa_d, sb_q, sb_d, bz_q, bz_d;

    logic           start;
    logic [W-1:0]   abs_a, abs_b;
    logic [W:0]     addend, mul_sum, rem_sh, rem_diff;
    logic [2*W-1:0] step_acc, prod_fix;
    logic [W-1:0]   quo_fix, rem_fix;

    // Datapath: one multiply or divide step per cycle, plus the FIX sign correction.
    always_comb begin
        start    = hiloW && (con[3:2] == 2'b11) && !abort;
        abs_a    = (con[1] && a[W-1]) ? -a : a;
        abs_b    = (con[1] && b[W-1]) ? -b : b;
        addend   = acc_q[0] ? {1'b0, opb_q} : '0;
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + addend;
        rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
        rem_diff = rem_sh - {1'b0, opb_q};
        if (div_q) begin
            // Restoring step: keep the difference only when it did not borrow.
            if (!rem_diff[W]) begin
                step_acc = {rem_diff[W-1:0], acc_q[W-2:0], 1'b1};
            end else begin
                step_acc = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
            end
        end else begin
            step_acc = {mul_sum, acc_q[W-1:1]};
        end
        prod_fix = (sgn_q && (sa_q ^ sb_q)) ? -acc_q : acc_q;
        quo_fix  = (sgn_q && (sa_q ^ sb_q)) ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem_fix  = (sgn_q && sa_q) ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opb_d   = opb_q;
        a_raw_d = a_raw_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        sgn_d   = sgn_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        bz_d    = bz_q;
        done    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StCalc;
                    div_d   = con[0];
                    sgn_d   = con[1];
                    sa_d    = con[1] & a[W-1];
                    sb_d    = con[1] & b[W-1];
                    bz_d    = (b == '0);
                    a_raw_d = a;
                    // Mul: acc holds the multiplier; div: acc holds the dividend.
                    opb_d   = con[0] ? abs_b : abs_a;
                    acc_d   = {{W{1'b0}}, (con[0] ? abs_a : abs_b)};
                    cnt_d   = CW'(W - 1);
                end
            end
            StCalc: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    acc_d = step_acc;
                    if (cnt_q == '0) begin
                        state_d = StFix;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            StFix: begin
                state_d = StIdle;
                if (!abort) begin
                    done = 1'b1;
                    if (!div_q) begin
                        {hi_d, lo_d} = prod_fix;
                    end else if (bz_q) begin
                        hi_d = a_raw_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        divz    = done & div_q & bz_q;
        busy    = (state_q != StIdle);
        stall   = busy & (hiloW | hiloR);
        hiloOut = hiloS ? lo_q : hi_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            hi_q    <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            a_raw_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            sgn_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
            a_raw_q <= a_raw_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            sgn_q   <= sgn_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            bz_q    <= bz_d;
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Randomized bench for muldiv_hilo_unit against a plain-arithmetic HI/LO model.
module tb_muldiv_hilo_unit;

    localparam int unsigned W = 32;

    logic         clk, rst_n, hiloW, hiloR, hiloS, abort;
    logic [3:0]   con;
    logic [W-1:0] a, b, hiloOut;
    logic         busy, stall, done, divz;

    int unsigned  n_tests, n_fail;
    logic [W-1:0] model_hi, model_lo;

    muldiv_hilo_unit #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .con     (con),
        .hiloW   (hiloW),
        .hiloR   (hiloR),
        .hiloS   (hiloS),
        .abort   (abort),
        .a       (a),
        .b       (b),
        .hiloOut (hiloOut),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .divz    (divz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void ref_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] h, output logic [31:0] l,
                                   output logic dz);
        longint sx, sy, q, r;
        logic [63:0] p;
        dz = 1'b0;
        if (!c[0]) begin
            if (c[1]) p = longint'($signed(x)) * longint'($signed(y));
            else      p = {32'b0, x} * {32'b0, y};
            {h, l} = p;
        end else if (y == 0) begin
            dz = 1'b1;
            h  = x;
            l  = '1;
        end else begin
            sx = c[1] ? longint'($signed(x)) : longint'({32'b0, x});
            sy = c[1] ? longint'($signed(y)) : longint'({32'b0, y});
            q  = sx / sy;
            r  = sx % sy;
            l  = q[31:0];
            h  = r[31:0];
        end
    endfunction

    // Called at a negedge with the unit idle; returns at the first idle cycle after the op.
    task automatic run_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                          input bit rd);
        int busy_cnt, stall_cnt, done_at;
        logic dz_seen, dz_other;
        logic [31:0] eh, el;
        logic edz;
        busy_cnt = 0; stall_cnt = 0; done_at = 0; dz_seen = 0; dz_other = 0;
        hiloW = 1'b1; con = c; a = x; b = y; hiloR = 1'b0;
        for (int i = 1; i <= int'(W) + 1; i++) begin
            @(negedge clk);
            hiloW = 1'b0;
            a = $urandom; b = $urandom;
            if (rd && i >= 5) begin
                hiloR = 1'b1;
                hiloS = 1'b1;
            end
            #1;
            if (busy) busy_cnt++;
            if (stall) stall_cnt++;
            if (done) begin
                done_at = i;
                dz_seen = divz;
            end else if (divz) begin
                dz_other = 1'b1;
            end
            if (i == int'(W) + 1) check("old_value", hiloOut, hiloS ? model_lo : model_hi);
        end
        ref_op(c, x, y, eh, el, edz);
        @(negedge clk);
        #1;
        if (rd) begin
            check("stall_released", stall, 0);
            check("read_new_lo", hiloOut, el);
            hiloR = 1'b0;
        end
        check("busy_after", busy, 0);
        check("busy_cycles", busy_cnt, W + 1);
        check("stall_cycles", stall_cnt, rd ? W - 3 : 0);
        check("done_cycle", done_at, W + 1);
        check("divz_with_done", dz_seen, edz);
        check("divz_stray", dz_other, 0);
        hiloS = 1'b0; #1;
        check($sformatf("hi c=%h a=%h b=%h", c, x, y), hiloOut, eh);
        hiloS = 1'b1; #1;
        check($sformatf("lo c=%h a=%h b=%h", c, x, y), hiloOut, el);
        model_hi = eh;
        model_lo = el;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  rc;
        logic [31:0] ra, rb;
        int          done_cnt;
        n_tests = 0; n_fail = 0;
        model_hi = '0; model_lo = '0;
        rst_n = 1'b0; hiloW = 0; hiloR = 0; hiloS = 0; abort = 0; con = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_stall", stall, 0);
        check("rst_done", done, 0);
        check("rst_divz", divz, 0);
        check("rst_hi", hiloOut, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(4'b1110, -32'sd7, 32'd3, 0);
        run_op(4'b1111, -32'sd7, 32'd2, 0);
        run_op(4'b1101, 32'h12345678, 32'd0, 0);
        run_op(4'b1111, 32'h80000000, 32'hFFFFFFFF, 0);
        run_op(4'b1100, $urandom, $urandom, 1);

        // Read and bogus write in idle.
        @(negedge clk);
        hiloR = 1'b1; hiloW = 1'b1; con = 4'b0010; #1;
        check("idle_read_stall", stall, 0);
        @(negedge clk);
        hiloR = 1'b0; hiloW = 1'b0; #1;
        check("bad_con_ignored", busy, 0);

        // Abort in idle with a simultaneous start.
        hiloW = 1'b1; con = 4'b1100; abort = 1'b1;
        @(negedge clk);
        hiloW = 1'b0; abort = 1'b0; #1;
        check("idle_abort_start", busy, 0);

        // Abort at CALC cycle 10 of a divide, then restart at once.
        hiloW = 1'b1; con = 4'b1101; a = $urandom; b = $urandom_range(1, 1000);
        done_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            hiloW = 1'b0;
            if (i == 10) abort = 1'b1;
            #1;
            if (done) done_cnt++;
        end
        @(negedge clk);
        abort = 1'b0; #1;
        if (done) done_cnt++;
        check("abort_busy", busy, 0);
        check("abort_no_done", done_cnt, 0);
        hiloS = 1'b0; #1;
        check("abort_hi_kept", hiloOut, model_hi);
        hiloS = 1'b1; #1;
        check("abort_lo_kept", hiloOut, model_lo);
        run_op(4'b1110, $urandom, $urandom, 0);

        // Randomized back-to-back operations.
        for (int n = 0; n < 24; n++) begin
            rc = 4'b1100 | 4'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'hFFFFFFFF;
                2: ra = 32'h80000000;
                3: rb = $urandom_range(1, 15);
                default: ;
            endcase
            run_op(rc, ra, rb, ($urandom_range(0, 3) == 0));
        end

        // Reset pulsed mid-CALC.
        hiloW = 1'b1; con = 4'b1100; a = $urandom; b = $urandom;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            hiloW = 1'b0;
        end
        rst_n = 1'b0; #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        hiloS = 1'b0; #1;
        check("midrst_hi", hiloOut, 0);
        hiloS = 1'b1; #1;
        check("midrst_lo", hiloOut, 0);
        model_hi = '0; model_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(4'b1111, $urandom, $urandom, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
